// File: rtl/div_pkg.sv
// Shared arithmetic-datapath package for the shift-subtract divider and the
// add-shift multiplier: default widths, FSM encoding, special-case constants
// and two's-complement magnitude/sign helpers.
package div_pkg;

    localparam int WA_DEF = 16;
    localparam int WB_DEF = 8;
    localparam int ITER   = WA_DEF;

    // Quotient written on signed overflow (-2^(WA-1) / -1) and on divide-by-zero
    localparam logic [WA_DEF-1:0] Q_OVF = 16'h8000;
    localparam logic [WA_DEF-1:0] Q_DZ  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Sign bit of a WA-wide two's-complement operand
    function automatic logic sign_wa(input logic [WA_DEF-1:0] v);
        return v[WA_DEF-1];
    endfunction

    // Sign bit of a WB-wide two's-complement operand
    function automatic logic sign_wb(input logic [WB_DEF-1:0] v);
        return v[WB_DEF-1];
    endfunction

    // Two's-complement negation at WA width
    function automatic logic [WA_DEF-1:0] neg_wa(input logic [WA_DEF-1:0] v);
        return ~v + {{(WA_DEF-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a WA-wide signed value, one bit wider so -2^(WA-1) is exact
    function automatic logic [WA_DEF:0] abs_wa(input logic [WA_DEF-1:0] v);
        logic [WA_DEF:0] ext;
        ext = {v[WA_DEF-1], v};
        if (v[WA_DEF-1]) begin
            return ~ext + {{WA_DEF{1'b0}}, 1'b1};
        end else begin
            return ext;
        end
    endfunction

    // Magnitude of a WB-wide signed value, one bit wider so -2^(WB-1) is exact
    function automatic logic [WB_DEF:0] abs_wb(input logic [WB_DEF-1:0] v);
        logic [WB_DEF:0] ext;
        ext = {v[WB_DEF-1], v};
        if (v[WB_DEF-1]) begin
            return ~ext + {{WB_DEF{1'b0}}, 1'b1};
        end else begin
            return ext;
        end
    endfunction

endpackage

// File: rtl/div_shift_sub_if.sv
// Start/done handshake bundle of the signed divider.
interface div_shift_sub_if
    import div_pkg::*;
#(
    parameter int WA = WA_DEF,
    parameter int WB = WB_DEF
) ();

    logic          start;
    logic [WA-1:0] A;
    logic [WB-1:0] B;
    logic [WA-1:0] Q;
    logic [WB-1:0] R;
    logic          busy;
    logic          done;
    logic          dz;
    logic          ovf;

    // Requester side: issues operands, receives results
    modport master (
        output start, A, B,
        input  Q, R, busy, done, dz, ovf
    );

    // Divider side
    modport slave (
        input  start, A, B,
        output Q, R, busy, done, dz, ovf
    );

endinterface

// File: rtl/div_sub_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor magnitude when it fits.
module div_sub_step #(
    parameter int WB = 8
) (
    input  logic [WB:0] rem,
    input  logic        bit_in,
    input  logic [WB:0] b_mag,
    output logic [WB:0] rem_next,
    output logic        q_bit
);

    logic [WB:0] shifted;
    logic        fits;

    // The shifted candidate is conceptually WB+2 bits wide; its top bit is
    // rem[WB], which makes the candidate exceed any divisor magnitude. The
    // difference always fits back into WB+1 bits.
    always_comb begin
        shifted  = {rem[WB-1:0], bit_in};
        fits     = rem[WB] | (shifted >= b_mag);
        rem_next = shifted;
        q_bit    = 1'b0;
        if (fits) begin
            rem_next = shifted - b_mag;
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted;
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_shift_sub.sv
// Sequential signed restoring divider. Fixed 17-clock latency from accept to
// done for every operand pair; divide-by-zero and overflow run the full
// iteration sequence and substitute their results at fix-up.
module div_shift_sub
    import div_pkg::*;
#(
    parameter int WA = WA_DEF,
    parameter int WB = WB_DEF
) (
    input logic            clk,
    input logic            rst,
    div_shift_sub_if.slave bus
);

    localparam int               CNT_W    = $clog2(WA);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WA - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             a_sign;
    logic             b_sign;
    logic             dz_pend;
    logic             ovf_pend;
    logic [WB:0]      b_mag;
    logic [WB:0]      rem;
    logic [WA-1:0]    quot;

    logic [WA-1:0]    q_out;
    logic [WB-1:0]    r_out;
    logic             busy_out;
    logic             done_out;
    logic             dz_out;
    logic             ovf_out;

    logic [WA-1:0]    a_mag_s;
    logic [WB:0]      b_ext_s;
    logic [WB:0]      b_mag_s;
    logic             is_dz_s;
    logic             is_ovf_s;
    logic [WB:0]      rem_next_s;
    logic             q_bit_s;
    logic [WA-1:0]    q_signed_s;
    logic [WB-1:0]    r_signed_s;

    // Operand magnitudes and special-case detection at the accept edge.
    // |A| never exceeds 2^(WA-1), which is exact as a WA-bit unsigned value.
    always_comb begin
        b_ext_s = {bus.B[WB-1], bus.B};
        if (bus.A[WA-1]) begin
            a_mag_s = ~bus.A + {{(WA-1){1'b0}}, 1'b1};
        end else begin
            a_mag_s = bus.A;
        end
        if (bus.B[WB-1]) begin
            b_mag_s = ~b_ext_s + {{WB{1'b0}}, 1'b1};
        end else begin
            b_mag_s = b_ext_s;
        end
        is_dz_s  = (bus.B == {WB{1'b0}});
        is_ovf_s = (bus.A == Q_OVF) && (bus.B == {WB{1'b1}});
    end

    div_sub_step #(
        .WB (WB)
    ) u_step (
        .rem      (rem),
        .bit_in   (quot[WA-1]),
        .b_mag    (b_mag),
        .rem_next (rem_next_s),
        .q_bit    (q_bit_s)
    );

    // Sign fix-up: quotient follows sign(A)^sign(B), remainder follows sign(A).
    // The stored remainder is below |B| <= 2^(WB-1), so its low WB bits hold it.
    always_comb begin
        if (a_sign ^ b_sign) begin
            q_signed_s = ~quot + {{(WA-1){1'b0}}, 1'b1};
        end else begin
            q_signed_s = quot;
        end
        if (a_sign) begin
            r_signed_s = ~rem[WB-1:0] + {{(WB-1){1'b0}}, 1'b1};
        end else begin
            r_signed_s = rem[WB-1:0];
        end
    end

    // Control FSM, iteration datapath and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= {CNT_W{1'b0}};
            a_sign   <= 1'b0;
            b_sign   <= 1'b0;
            dz_pend  <= 1'b0;
            ovf_pend <= 1'b0;
            b_mag    <= {(WB+1){1'b0}};
            rem      <= {(WB+1){1'b0}};
            quot     <= {WA{1'b0}};
            q_out    <= {WA{1'b0}};
            r_out    <= {WB{1'b0}};
            busy_out <= 1'b0;
            done_out <= 1'b0;
            dz_out   <= 1'b0;
            ovf_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_out <= 1'b0;
                    if (bus.start) begin
                        a_sign   <= bus.A[WA-1];
                        b_sign   <= bus.B[WB-1];
                        b_mag    <= b_mag_s;
                        quot     <= a_mag_s;
                        rem      <= {(WB+1){1'b0}};
                        dz_pend  <= is_dz_s;
                        ovf_pend <= is_ovf_s;
                        cnt      <= {CNT_W{1'b0}};
                        busy_out <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // quot doubles as the dividend shift register: its MSB
                    // feeds the step, the new quotient bit enters at the LSB
                    rem  <= rem_next_s;
                    quot <= {quot[WA-2:0], q_bit_s};
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                FIX: begin
                    if (dz_pend) begin
                        q_out   <= Q_DZ;
                        r_out   <= {WB{1'b0}};
                        dz_out  <= 1'b1;
                        ovf_out <= 1'b0;
                    end else if (ovf_pend) begin
                        q_out   <= Q_OVF;
                        r_out   <= {WB{1'b0}};
                        dz_out  <= 1'b0;
                        ovf_out <= 1'b1;
                    end else begin
                        q_out   <= q_signed_s;
                        r_out   <= r_signed_s;
                        dz_out  <= 1'b0;
                        ovf_out <= 1'b0;
                    end
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    busy_out <= 1'b0;
                    done_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.Q    = q_out;
    assign bus.R    = r_out;
    assign bus.busy = busy_out;
    assign bus.done = done_out;
    assign bus.dz   = dz_out;
    assign bus.ovf  = ovf_out;

endmodule

// File: tb/tb_div_shift_sub.sv
// Directed scoreboard bench for div_shift_sub.
module tb_div_shift_sub;
    import div_pkg::*;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_shift_sub_if bus ();

    div_shift_sub dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model built on the simulator's own signed division
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        int   ai;
        int   bi;
        int   qi;
        int   ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            e = '{q: 16'hFFFF, r: 8'h00, dz: 1'b1, ovf: 1'b0};
        end else if (ai == -32768 && bi == -1) begin
            e = '{q: 16'h8000, r: 8'h00, dz: 1'b0, ovf: 1'b1};
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            e.q = qi[15:0];
            e.r = ri[7:0];
            e.dz = 1'b0;
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one cycle; returns #1 after the accept edge
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 16'($urandom);
        bus.B     = 8'($urandom);
    endtask

    // Wait for done, check latency/busy and compare against the scoreboard.
    // Optionally pulses start at busy cycle pulse_at. Returns in the done cycle.
    task automatic finish_op(input string tag, input int pulse_at);
        int   n;
        int   busy_n;
        bit   seen;
        exp_t e;
        n      = 0;
        seen   = 1'b0;
        busy_n = bus.busy ? 1 : 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == pulse_at) begin
                bus.start = 1'b1;
                bus.A     = 16'd7;
                bus.B     = 8'd1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen = 1'b1;
            end else if (bus.busy) begin
                busy_n++;
            end
        end
        check({tag, "_latency"}, seen ? n : 0, 17);
        check({tag, "_busy_cycles"}, busy_n, 17);
        check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_Q"}, {16'd0, bus.Q}, {16'd0, e.q});
            check({tag, "_R"}, {24'd0, bus.R}, {24'd0, e.r});
            check({tag, "_dz"}, {31'd0, bus.dz}, {31'd0, e.dz});
            check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, e.ovf});
        end
    endtask

    initial begin
        int dones;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = 16'd0;
        bus.B     = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_Q", {16'd0, bus.Q}, 0);
        check("rst_R", {24'd0, bus.R}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_dz", {31'd0, bus.dz}, 0);
        check("rst_ovf", {31'd0, bus.ovf}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic operation, then confirm done is a single-cycle pulse
        start_op(16'd100, 8'd7);
        finish_op("p100_p7", 0);
        @(posedge clk);
        #1;
        check("done_width", {31'd0, bus.done}, 0);
        check("idle_busy", {31'd0, bus.busy}, 0);

        // Chain of back-to-back operations: each start is raised in the done cycle
        start_op(-16'sd100, 8'd7);
        finish_op("m100_p7", 0);
        start_op(16'd100, -8'sd7);
        finish_op("p100_m7", 0);
        start_op(-16'sd100, -8'sd7);
        finish_op("m100_m7", 0);
        start_op(16'd1234, 8'd0);
        finish_op("div_zero", 0);
        start_op(16'h8000, 8'hFF);
        finish_op("overflow", 0);
        start_op(16'h8000, 8'h80);
        finish_op("min_min", 0);
        start_op(16'd32767, 8'd1);
        finish_op("max_one", 0);
        start_op(16'd32767, 8'h80);
        finish_op("max_minb", 0);
        start_op(16'h8000, 8'd1);
        finish_op("min_one", 0);

        // Start during busy is ignored and not queued
        @(posedge clk);
        #1;
        start_op(16'h1234, 8'd3);
        finish_op("ignored_start", 5);
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dones++;
        end
        check("no_queued_op", dones, 0);

        // Reset in the middle of CALC aborts without a done pulse
        start_op(16'd5000, 8'd9);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_Q", {16'd0, bus.Q}, 0);
        check("abort_R", {24'd0, bus.R}, 0);
        check("abort_busy", {31'd0, bus.busy}, 0);
        check("abort_done", {31'd0, bus.done}, 0);
        check("abort_dz", {31'd0, bus.dz}, 0);
        check("abort_ovf", {31'd0, bus.ovf}, 0);
        void'(sb.pop_front());
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        dones = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);
        start_op(16'd45, 8'd6);
        finish_op("p45_p6", 0);

        // A few pseudo-random operand pairs
        for (int i = 0; i < 6; i++) begin
            start_op(16'($urandom), 8'($urandom));
            finish_op("random", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
